// File: rtl/potential_bank_rr.sv
// Shared membrane-potential store: round-robin read/write arbitration, registered
// read with write bypass, per-entry freshness flags and an init sweep FSM.

module potential_bank_rr_arb #(
  parameter int N  = 6,
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  gnt,
  output logic [CW-1:0] idx,
  output logic          any
);
  logic [CW-1:0] ptr_q, ptr_d;

  // Search upward from the pointer with wrap; first asserted request wins.
  always_comb begin
    int            c;
    logic [CW-1:0] c_idx;
    c     = 0;
    c_idx = '0;
    gnt   = '0;
    idx   = '0;
    any   = 1'b0;
    for (int i = 0; i < N; i++) begin
      c = int'(ptr_q) + i;
      if (c >= N) c = c - N;
      c_idx = CW'(c);
      if (en && !any && req[c_idx]) begin
        any        = 1'b1;
        idx        = c_idx;
        gnt[c_idx] = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (any) ptr_d = (int'(idx) == N - 1) ? '0 : idx + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ptr_q <= '0;
    else      ptr_q <= ptr_d;
  end
endmodule

module potential_bank_rr #(
  parameter int               WIDTH    = 32,
  parameter int               DEPTH    = 16,
  parameter int               NUM_CH   = 6,
  parameter logic [WIDTH-1:0] INIT_VAL = '0,
  parameter int               AW       = $clog2(DEPTH),
  parameter int               CW       = $clog2(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic [NUM_CH-1:0]       rd_req,
  input  logic [NUM_CH*AW-1:0]    rd_addr,
  input  logic [NUM_CH-1:0]       wr_req,
  input  logic [NUM_CH*AW-1:0]    wr_addr,
  input  logic [NUM_CH*WIDTH-1:0] wr_data,
  output logic [NUM_CH-1:0]       rd_gnt,
  output logic [NUM_CH-1:0]       wr_gnt,
  output logic                    rd_valid,
  output logic [CW-1:0]           rd_ch,
  output logic [WIDTH-1:0]        rd_data,
  output logic                    rd_fresh,
  output logic                    busy
);
  typedef enum logic {S_SWEEP, S_IDLE} state_e;

  state_e           state_q, state_d;
  logic [AW-1:0]    sweep_addr_q, sweep_addr_d;
  logic             busy_q;
  logic [DEPTH-1:0] flag_q, flag_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic             mem_we;
  logic [AW-1:0]    mem_waddr;
  logic [WIDTH-1:0] mem_wdata;

  logic             rd_valid_q;
  logic [CW-1:0]    rd_ch_q;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             rd_fresh_q, rd_fresh_d;

  logic [AW-1:0]    rd_addr_a [NUM_CH];
  logic [AW-1:0]    wr_addr_a [NUM_CH];
  logic [WIDTH-1:0] wr_data_a [NUM_CH];

  logic             arb_en;
  logic             rd_any, wr_any;
  logic [CW-1:0]    rd_idx, wr_idx;
  logic [AW-1:0]    rd_a, wr_a;
  logic [WIDTH-1:0] wr_d;
  logic             rd_ok, wr_ok;
  logic             wr_commit, rd_commit;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_unpack
      assign rd_addr_a[gi] = rd_addr[gi*AW +: AW];
      assign wr_addr_a[gi] = wr_addr[gi*AW +: AW];
      assign wr_data_a[gi] = wr_data[gi*WIDTH +: WIDTH];
    end
  endgenerate

  assign arb_en = (state_q == S_IDLE) && !busy_q && !clear;

  potential_bank_rr_arb #(.N(NUM_CH), .CW(CW)) u_rd_arb (
    .clk(clk), .rst(rst), .en(arb_en), .req(rd_req),
    .gnt(rd_gnt), .idx(rd_idx), .any(rd_any)
  );

  potential_bank_rr_arb #(.N(NUM_CH), .CW(CW)) u_wr_arb (
    .clk(clk), .rst(rst), .en(arb_en), .req(wr_req),
    .gnt(wr_gnt), .idx(wr_idx), .any(wr_any)
  );

  assign rd_a = rd_addr_a[rd_idx];
  assign wr_a = wr_addr_a[wr_idx];
  assign wr_d = wr_data_a[wr_idx];

  // Out-of-range addresses only exist when DEPTH is not a power of two.
  generate
    if (DEPTH == (1 << AW)) begin : g_pow2
      assign rd_ok = 1'b1;
      assign wr_ok = 1'b1;
    end else begin : g_npow2
      assign rd_ok = ({1'b0, rd_a} < (AW+1)'(DEPTH));
      assign wr_ok = ({1'b0, wr_a} < (AW+1)'(DEPTH));
    end
  endgenerate

  assign wr_commit = wr_any && wr_ok;
  assign rd_commit = rd_any && rd_ok;

  always_comb begin
    state_d      = state_q;
    sweep_addr_d = sweep_addr_q;
    mem_we       = 1'b0;
    mem_waddr    = '0;
    mem_wdata    = '0;
    case (state_q)
      S_SWEEP: begin
        if (clear) begin
          sweep_addr_d = '0;
        end else begin
          mem_we    = 1'b1;
          mem_waddr = sweep_addr_q;
          mem_wdata = INIT_VAL;
          if (sweep_addr_q == AW'(DEPTH - 1)) begin
            state_d      = S_IDLE;
            sweep_addr_d = '0;
          end else begin
            sweep_addr_d = sweep_addr_q + 1'b1;
          end
        end
      end
      S_IDLE: begin
        if (clear) begin
          state_d      = S_SWEEP;
          sweep_addr_d = '0;
        end else if (wr_commit) begin
          mem_we    = 1'b1;
          mem_waddr = wr_a;
          mem_wdata = wr_d;
        end
      end
      default: state_d = S_SWEEP;
    endcase
  end

  // Read clear is applied before write set so a same-address write wins.
  always_comb begin
    flag_d = flag_q;
    if (state_q == S_SWEEP && !clear) flag_d[sweep_addr_q] = 1'b1;
    if (rd_commit)                    flag_d[rd_a]         = 1'b0;
    if (wr_commit)                    flag_d[wr_a]         = 1'b1;
  end

  always_comb begin
    rd_data_d  = '0;
    rd_fresh_d = 1'b0;
    if (rd_ok) begin
      if (wr_commit && (wr_a == rd_a)) begin
        rd_data_d  = wr_d;
        rd_fresh_d = 1'b1;
      end else begin
        rd_data_d  = mem_q[rd_a];
        rd_fresh_d = flag_q[rd_a];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_SWEEP;
      sweep_addr_q <= '0;
      busy_q       <= 1'b1;
      flag_q       <= '1;
    end else begin
      state_q      <= state_d;
      sweep_addr_q <= sweep_addr_d;
      busy_q       <= (state_d == S_SWEEP);
      flag_q       <= flag_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_valid_q <= 1'b0;
      rd_ch_q    <= '0;
      rd_data_q  <= '0;
      rd_fresh_q <= 1'b0;
    end else if (rd_any) begin
      rd_valid_q <= 1'b1;
      rd_ch_q    <= rd_idx;
      rd_data_q  <= rd_data_d;
      rd_fresh_q <= rd_fresh_d;
    end else begin
      rd_valid_q <= 1'b0;
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_ch    = rd_ch_q;
  assign rd_data  = rd_data_q;
  assign rd_fresh = rd_fresh_q;
  assign busy     = busy_q;
endmodule

// File: tb/tb_potential_bank_rr.sv
// Directed bench for potential_bank_rr: init sweep, round-robin order, bypass,
// freshness flags, clear and asynchronous reset.

module tb_potential_bank_rr;
  localparam int WIDTH  = 32;
  localparam int DEPTH  = 16;
  localparam int NUM_CH = 6;
  localparam int AW     = 4;
  localparam int CW     = 3;

  logic                    clk;
  logic                    rst;
  logic                    clear;
  logic [NUM_CH-1:0]       rd_req;
  logic [NUM_CH*AW-1:0]    rd_addr;
  logic [NUM_CH-1:0]       wr_req;
  logic [NUM_CH*AW-1:0]    wr_addr;
  logic [NUM_CH*WIDTH-1:0] wr_data;
  logic [NUM_CH-1:0]       rd_gnt;
  logic [NUM_CH-1:0]       wr_gnt;
  logic                    rd_valid;
  logic [CW-1:0]           rd_ch;
  logic [WIDTH-1:0]        rd_data;
  logic                    rd_fresh;
  logic                    busy;

  int n_chk  = 0;
  int n_pass = 0;

  potential_bank_rr #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_CH(NUM_CH), .INIT_VAL('0)
  ) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .rd_req(rd_req), .rd_addr(rd_addr),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_gnt(rd_gnt), .wr_gnt(wr_gnt),
    .rd_valid(rd_valid), .rd_ch(rd_ch), .rd_data(rd_data), .rd_fresh(rd_fresh),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Single-channel read issued at posedge+1, returned data visible after the next edge.
  task automatic do_read(input int ch, input int addr);
    rd_req     = '0;
    rd_req[ch] = 1'b1;
    rd_addr[ch*AW +: AW] = AW'(addr);
    cyc();
    rd_req = '0;
    $display("read  ch%0d addr %0d -> valid %b ch %0d data %h fresh %b",
             ch, addr, rd_valid, rd_ch, rd_data, rd_fresh);
  endtask

  task automatic do_write(input int ch, input int addr, input logic [WIDTH-1:0] data);
    wr_req     = '0;
    wr_req[ch] = 1'b1;
    wr_addr[ch*AW +: AW]       = AW'(addr);
    wr_data[ch*WIDTH +: WIDTH] = data;
    cyc();
    wr_req = '0;
    $display("write ch%0d addr %0d data %h", ch, addr, data);
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b0; clear = 1'b0;
    rd_req = '0; wr_req = '0; rd_addr = '0; wr_addr = '0; wr_data = '0;
    repeat (3) cyc();
    rd_req = '1; #1;
    n_chk++; if (busy !== 1'b1) $display("FAIL reset_busy got %b exp 1", busy); else n_pass++;
    n_chk++; if (rd_valid !== 1'b0) $display("FAIL reset_rd_valid got %b exp 0", rd_valid); else n_pass++;
    n_chk++; if (rd_ch !== 3'd0) $display("FAIL reset_rd_ch got %0d exp 0", rd_ch); else n_pass++;
    n_chk++; if (rd_data !== 32'h0) $display("FAIL reset_rd_data got %h exp 0", rd_data); else n_pass++;
    n_chk++; if (rd_fresh !== 1'b0) $display("FAIL reset_rd_fresh got %b exp 0", rd_fresh); else n_pass++;
    n_chk++; if (rd_gnt !== 6'b0) $display("FAIL reset_rd_gnt got %b exp 000000", rd_gnt); else n_pass++;
    rd_req = '0;
    rst = 1'b1;
    n = 0;
    while (busy === 1'b1 && n < 40) begin n++; cyc(); end
    $display("sweep after reset release: busy cycles %0d", n);
    n_chk++; if (n != 16) $display("FAIL reset_busy_len got %0d exp 16", n); else n_pass++;
    for (int a = 0; a < DEPTH; a++) begin
      do_read(0, a);
      n_chk++; if (rd_valid !== 1'b1 || rd_data !== 32'h0 || rd_fresh !== 1'b1)
        $display("FAIL init_read1 addr %0d got valid %b data %h fresh %b exp 1 0 1", a, rd_valid, rd_data, rd_fresh);
      else n_pass++;
      do_read(0, a);
      n_chk++; if (rd_valid !== 1'b1 || rd_fresh !== 1'b0)
        $display("FAIL init_read2 addr %0d got valid %b fresh %b exp 1 0", a, rd_valid, rd_fresh);
      else n_pass++;
    end
  endtask

  task automatic test_round_robin();
    logic [NUM_CH-1:0] exp_g;
    do_read(5, 0);
    rd_addr = '0;
    rd_req  = '1;
    #1;
    for (int i = 0; i < 7; i++) begin
      exp_g = NUM_CH'(1 << (i % 6));
      n_chk++; if (rd_gnt !== exp_g) $display("FAIL rr_gnt step %0d got %b exp %b", i, rd_gnt, exp_g); else n_pass++;
      cyc();
      $display("rr step %0d: valid %b ch %0d", i, rd_valid, rd_ch);
      n_chk++; if (rd_valid !== 1'b1 || rd_ch !== CW'(i % 6))
        $display("FAIL rr_ch step %0d got valid %b ch %0d exp 1 %0d", i, rd_valid, rd_ch, i % 6);
      else n_pass++;
    end
    rd_req = '0;
  endtask

  task automatic test_bypass();
    wr_req = 6'b000100;
    wr_addr[2*AW +: AW] = 4'd5;
    wr_data[2*WIDTH +: WIDTH] = 32'hDEADBEEF;
    rd_req = 6'b010000;
    rd_addr[4*AW +: AW] = 4'd5;
    #1;
    n_chk++; if (wr_gnt !== 6'b000100) $display("FAIL byp_wr_gnt got %b exp 000100", wr_gnt); else n_pass++;
    n_chk++; if (rd_gnt !== 6'b010000) $display("FAIL byp_rd_gnt got %b exp 010000", rd_gnt); else n_pass++;
    cyc();
    wr_req = '0; rd_req = '0;
    $display("bypass: valid %b ch %0d data %h fresh %b", rd_valid, rd_ch, rd_data, rd_fresh);
    n_chk++; if (rd_valid !== 1'b1 || rd_ch !== 3'd4) $display("FAIL byp_ch got valid %b ch %0d exp 1 4", rd_valid, rd_ch); else n_pass++;
    n_chk++; if (rd_data !== 32'hDEADBEEF) $display("FAIL byp_data got %h exp deadbeef", rd_data); else n_pass++;
    n_chk++; if (rd_fresh !== 1'b1) $display("FAIL byp_fresh got %b exp 1", rd_fresh); else n_pass++;
    do_read(1, 5);
    n_chk++; if (rd_data !== 32'hDEADBEEF || rd_fresh !== 1'b1)
      $display("FAIL byp_reread got data %h fresh %b exp deadbeef 1", rd_data, rd_fresh);
    else n_pass++;
    do_read(1, 5);
    n_chk++; if (rd_fresh !== 1'b0) $display("FAIL byp_reread2 got fresh %b exp 0", rd_fresh); else n_pass++;
  endtask

  task automatic test_diff_addr();
    wr_req = 6'b000001;
    wr_addr[0 +: AW] = 4'd3;
    wr_data[0 +: WIDTH] = 32'h10;
    rd_req = 6'b000010;
    rd_addr[1*AW +: AW] = 4'd7;
    cyc();
    wr_req = '0; rd_req = '0;
    $display("diff: valid %b ch %0d data %h fresh %b", rd_valid, rd_ch, rd_data, rd_fresh);
    n_chk++; if (rd_valid !== 1'b1 || rd_ch !== 3'd1 || rd_data !== 32'h0 || rd_fresh !== 1'b0)
      $display("FAIL diff_same_cycle got valid %b ch %0d data %h fresh %b exp 1 1 0 0", rd_valid, rd_ch, rd_data, rd_fresh);
    else n_pass++;
    do_read(2, 3);
    n_chk++; if (rd_data !== 32'h10 || rd_fresh !== 1'b1)
      $display("FAIL diff_addr3 got data %h fresh %b exp 10 1", rd_data, rd_fresh);
    else n_pass++;
    do_read(3, 7);
    n_chk++; if (rd_data !== 32'h0 || rd_fresh !== 1'b0)
      $display("FAIL diff_addr7 got data %h fresh %b exp 0 0", rd_data, rd_fresh);
    else n_pass++;
  endtask

  task automatic test_clear();
    int   n;
    logic gnt_seen;
    do_write(1, 9, 32'h55);
    do_read(0, 9);
    n_chk++; if (rd_data !== 32'h55 || rd_fresh !== 1'b1)
      $display("FAIL clr_pre got data %h fresh %b exp 55 1", rd_data, rd_fresh);
    else n_pass++;
    rd_req = '1; wr_req = '1; clear = 1'b1;
    #1;
    n_chk++; if (rd_gnt !== 6'b0) $display("FAIL clr_rd_gnt got %b exp 000000", rd_gnt); else n_pass++;
    n_chk++; if (wr_gnt !== 6'b0) $display("FAIL clr_wr_gnt got %b exp 000000", wr_gnt); else n_pass++;
    cyc();
    clear = 1'b0; wr_req = '0;
    n = 0; gnt_seen = 1'b0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      if (rd_gnt !== 6'b0) gnt_seen = 1'b1;
      cyc();
    end
    rd_req = '0;
    $display("clear sweep: busy cycles %0d", n);
    n_chk++; if (n != 16) $display("FAIL clr_busy_len got %0d exp 16", n); else n_pass++;
    n_chk++; if (gnt_seen !== 1'b0) $display("FAIL clr_gnt_in_sweep got %b exp 0", gnt_seen); else n_pass++;
    do_read(0, 9);
    n_chk++; if (rd_data !== 32'h0 || rd_fresh !== 1'b1)
      $display("FAIL clr_addr9 got data %h fresh %b exp 0 1", rd_data, rd_fresh);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int n;
    do_write(2, 5, 32'hCAFE0001);
    do_read(3, 5);
    n_chk++; if (rd_ch !== 3'd3 || rd_data !== 32'hCAFE0001)
      $display("FAIL rstm_pre got ch %0d data %h exp 3 cafe0001", rd_ch, rd_data);
    else n_pass++;
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    repeat (6) cyc();
    @(negedge clk);
    rst = 1'b0;
    #1;
    $display("reset mid-sweep: busy %b valid %b ch %0d data %h fresh %b", busy, rd_valid, rd_ch, rd_data, rd_fresh);
    n_chk++; if (busy !== 1'b1) $display("FAIL rstm_busy got %b exp 1", busy); else n_pass++;
    n_chk++; if (rd_ch !== 3'd0 || rd_data !== 32'h0 || rd_fresh !== 1'b0 || rd_valid !== 1'b0)
      $display("FAIL rstm_outputs got valid %b ch %0d data %h fresh %b exp 0 0 0 0", rd_valid, rd_ch, rd_data, rd_fresh);
    else n_pass++;
    cyc(); cyc();
    rst = 1'b1;
    n = 0;
    while (busy === 1'b1 && n < 40) begin n++; cyc(); end
    $display("sweep after mid reset: busy cycles %0d", n);
    n_chk++; if (n != 16) $display("FAIL rstm_busy_len got %0d exp 16", n); else n_pass++;
    do_read(4, 5);
    n_chk++; if (rd_valid !== 1'b1 || rd_ch !== 3'd4 || rd_data !== 32'h0 || rd_fresh !== 1'b1)
      $display("FAIL rstm_read got valid %b ch %0d data %h fresh %b exp 1 4 0 1", rd_valid, rd_ch, rd_data, rd_fresh);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_bypass();
    test_diff_addr();
    test_clear();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
